ssd_freq_meter: RTL and testbench

SSD_FREQ_METER -- requirements
Module: ssd_freq_meter

---
 rtl/ssd_freq_meter.sv | 147 ++++++++++++++
 tb/tb_ssd_freq_meter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_freq_meter.sv
// Frequency meter for a seven-segment display front end.
// Counts rising edges of an asynchronous input over a fixed gate window of
// GATE_CYCLES clocks and presents the saturated count, with an overflow flag,
// once per window. Windows run back to back while enable is high.
module ssd_freq_meter #(
  parameter int unsigned GATE_CYCLES = 32'd100000000,
  parameter int unsigned MAX_COUNT   = 32'd9999,
  parameter int          COUNT_WIDTH = 14
) (
  input  logic                   clock_in,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] freq_count,
  output logic                   count_valid,
  output logic                   overflow,
  output logic                   gate
);

  localparam logic [31:0]            GATE_LAST = 32'(GATE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] MAX_CNT   = COUNT_WIDTH'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Synchronizer stages and edge history
  logic s1, s2, s3;
  logic edge_det;

  // Window bookkeeping
  logic [31:0]            gate_cnt;
  logic [COUNT_WIDTH-1:0] edge_cnt, edge_cnt_nxt;
  logic                   pend, pend_nxt;
  logic [1:0]             settle_cnt;
  logic                   terminal;
  logic                   load;

  // Saturating increment: the count sticks at MAX_CNT.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] cnt);
    if (cnt == MAX_CNT) begin
      return cnt;
    end
    return cnt + COUNT_WIDTH'(1);
  endfunction

  // An edge arriving while already saturated marks the window as overflowed.
  function automatic logic sat_hit(input logic [COUNT_WIDTH-1:0] cnt);
    return (cnt == MAX_CNT);
  endfunction

  assign edge_det = s2 & ~s3;
  assign terminal = (state == MEASURE) && (gate_cnt == GATE_LAST);
  // Abort has priority over a window closing in the same cycle.
  assign load     = terminal && enable;

  // Count and pending flag including any edge detected this cycle
  always_comb begin
    edge_cnt_nxt = edge_cnt;
    pend_nxt     = pend;
    if (edge_det) begin
      edge_cnt_nxt = sat_inc(edge_cnt);
      pend_nxt     = pend | sat_hit(edge_cnt);
    end
  end

  // State register
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; dropping enable always returns to IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (enable) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!enable)                 state_nxt = IDLE;
        else if (settle_cnt == 2'd2) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (!enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    gate = (state == MEASURE);
  end

  // Input synchronizer, window counters and result registers
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s3          <= 1'b0;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      pend        <= 1'b0;
      settle_cnt  <= '0;
      freq_count  <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;

      count_valid <= load;
      if (load) begin
        freq_count <= edge_cnt_nxt;
        overflow   <= pend_nxt;
      end

      // Counters run only inside a live window; everything else, including
      // the terminal cycle, restarts them at zero so the next window has no gap.
      if ((state == MEASURE) && enable && !terminal) begin
        gate_cnt <= gate_cnt + 32'd1;
        edge_cnt <= edge_cnt_nxt;
        pend     <= pend_nxt;
      end else begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        pend     <= 1'b0;
      end

      if ((state == SETTLE) && enable) begin
        settle_cnt <= settle_cnt + 2'd1;
      end else begin
        settle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ssd_freq_meter.sv
// Bench for ssd_freq_meter with a 20-cycle window and a 0..9 count range.
// Expected window results are queued as stimulus is applied and compared
// whenever count_valid pulses.
module tb_ssd_freq_meter;

  localparam int unsigned GATE = 20;
  localparam int unsigned MAXC = 9;
  localparam int          CW   = 4;

  logic          clock_in;
  logic          reset_n;
  logic          enable;
  logic          sig_in;
  logic [CW-1:0] freq_count;
  logic          count_valid;
  logic          overflow;
  logic          gate;

  typedef struct {
    bit chk;
    int cnt;
    int ovf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mode     = 0;   // 0 low, 1 period-4, 2 period-2, 3 manual
  int   ph       = 0;

  ssd_freq_meter #(
    .GATE_CYCLES(GATE),
    .MAX_COUNT  (MAXC),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .enable     (enable),
    .sig_in     (sig_in),
    .freq_count (freq_count),
    .count_valid(count_valid),
    .overflow   (overflow),
    .gate       (gate)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock and apply the next sig_in sample just after the edge.
  task automatic step();
    @(posedge clock_in);
    #1;
    case (mode)
      0:       sig_in = 1'b0;
      1:       sig_in = ph[1];
      2:       sig_in = ph[0];
      default: sig_in = sig_in;
    endcase
    ph++;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!count_valid && n < 100);
    if (!count_valid) check_val("valid_timeout", 0, 1);
  endtask

  task automatic push(input bit chk, input int cnt, input int ovf);
    exp_t e;
    e.chk = chk;
    e.cnt = cnt;
    e.ovf = ovf;
    q.push_back(e);
  endtask

  // Scoreboard: every count_valid must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock_in);
      #1;
      if (count_valid) begin
        if (q.size() == 0) begin
          check_val("unexpected_valid", 1, 0);
        end else begin
          e = q.pop_front();
          if (e.chk) begin
            check_val("freq_count", int'(freq_count), e.cnt);
            check_val("overflow", int'(overflow), e.ovf);
          end
        end
      end
    end
  end

  initial begin
    int n;
    reset_n = 1'b0;
    enable  = 1'b0;
    sig_in  = 1'b0;
    repeat (3) step();
    check_val("rst_freq_count", int'(freq_count), 0);
    check_val("rst_overflow", int'(overflow), 0);
    check_val("rst_count_valid", int'(count_valid), 0);
    check_val("rst_gate", int'(gate), 0);

    // Period-4 input: 5 edges per window, settle then back-to-back windows
    push(1, 5, 0);
    push(1, 5, 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    mode    = 1;
    ph      = 0;
    repeat (3) begin
      step();
      check_val("settle_gate", int'(gate), 0);
    end
    step();
    check_val("gate_rise", int'(gate), 1);
    wait_valid(n);
    check_val("win_len1", n, 20);
    wait_valid(n);
    check_val("win_len2", n, 20);

    // Period-2 input: 10 edges saturate at 9 with overflow
    mode = 2;
    push(0, 0, 0);
    push(1, 9, 1);
    wait_valid(n);
    wait_valid(n);

    // Input held low: empty window
    mode = 0;
    push(0, 0, 0);
    push(1, 0, 0);
    wait_valid(n);
    wait_valid(n);

    // Edge detected in the terminal cycle, then one in a window's first cycle
    mode = 3;
    push(1, 1, 0);
    push(1, 0, 0);
    push(1, 1, 0);
    repeat (17) step();
    sig_in = 1'b1;
    wait_valid(n);
    check_val("term_edge_lat", n, 3);
    repeat (5) step();
    sig_in = 1'b0;
    repeat (13) step();
    sig_in = 1'b1;
    wait_valid(n);
    repeat (5) step();
    sig_in = 1'b0;
    wait_valid(n);

    // Abort at gate count 10: result held, no pulse, fresh window afterwards
    repeat (10) step();
    enable = 1'b0;
    step();
    check_val("abort_gate", int'(gate), 0);
    check_val("abort_valid", int'(count_valid), 0);
    check_val("abort_hold", int'(freq_count), 1);
    repeat (30) step();
    check_val("idle_hold", int'(freq_count), 1);
    check_val("idle_gate", int'(gate), 0);
    mode   = 1;
    ph     = 0;
    enable = 1'b1;
    push(1, 5, 0);
    repeat (3) begin
      step();
      check_val("resettle_gate", int'(gate), 0);
    end
    step();
    check_val("regate_rise", int'(gate), 1);
    wait_valid(n);
    check_val("win_len3", n, 20);

    // Reset mid-window clears the held result
    repeat (8) step();
    reset_n = 1'b0;
    step();
    check_val("mid_rst_freq", int'(freq_count), 0);
    check_val("mid_rst_ovf", int'(overflow), 0);
    check_val("mid_rst_gate", int'(gate), 0);
    check_val("mid_rst_valid", int'(count_valid), 0);
    repeat (5) step();
    push(1, 5, 0);
    reset_n = 1'b1;
    repeat (3) begin
      step();
      check_val("post_rst_gate", int'(gate), 0);
    end
    step();
    check_val("post_rst_rise", int'(gate), 1);
    wait_valid(n);
    check_val("win_len4", n, 20);

    // Enable dropped in the terminal cycle: abort wins, nothing loads
    mode = 0;
    repeat (19) step();
    enable = 1'b0;
    step();
    check_val("term_abort_valid", int'(count_valid), 0);
    check_val("term_abort_gate", int'(gate), 0);
    check_val("term_abort_hold", int'(freq_count), 5);
    repeat (25) step();
    check_val("term_abort_hold2", int'(freq_count), 5);
    check_val("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
